sm_collector: RTL and testbench

Receive-side endpoint of the sorter's sorted-memory (SM) write interface. Captures each `SM_valid`/`SM_addr`/`SM_data` write into a local buffer of `ELEMENT_NUM` entries and checks address sequence, count and sort order. On the sorter's `done`, it streams the buffered result out over a valid/ready port. It sits directly downstream of the sorter and replaces a passive SM memory in system and verification builds.

---
 rtl/sm_collector.sv | 178 +++++++++++++++++
 tb/tb_sm_collector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_collector.sv
`default_nettype none
// ============================================================================
//  Module      : sm_collector
//  Description : Receive-side endpoint of the sorter's sorted-memory write
//                port. Buffers one batch of ELEMENT_NUM writes, flags address
//                sequence, count and sort-order faults, then streams the
//                buffered batch out over a valid/ready port once the sorter
//                signals done.
//  Revision    : 1.0  initial release
// ============================================================================
module sm_collector #(
    parameter int DATA_WIDTH       = 8,
    parameter int ELEMENT_NUM      = 16,
    parameter int LOG2_ELEMENT_NUM = 4,
    parameter int ASCENDING        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SM_valid,
    input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
    input  logic [DATA_WIDTH-1:0]       SM_data,
    input  logic                        sorter_done,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic                        complete,
    output logic                        addr_err,
    output logic                        count_err,
    output logic                        order_err
);

    localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_ADDR = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);
    localparam logic [LOG2_ELEMENT_NUM-1:0] ADDR_ONE  = LOG2_ELEMENT_NUM'(1);
    localparam logic [LOG2_ELEMENT_NUM:0]   CNT_ONE   = (LOG2_ELEMENT_NUM + 1)'(1);
    localparam logic [LOG2_ELEMENT_NUM:0]   CNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    state_t                        state;
    state_t                        state_nxt;

    logic [DATA_WIDTH-1:0]         mem [ELEMENT_NUM];
    logic [DATA_WIDTH-1:0]         prev_data;
    logic [LOG2_ELEMENT_NUM-1:0]   exp_addr;
    logic [LOG2_ELEMENT_NUM-1:0]   rd_ptr;
    logic [LOG2_ELEMENT_NUM-1:0]   rd_ptr_inc;
    logic [LOG2_ELEMENT_NUM:0]     wr_cnt;

    logic                          cap_we;
    logic                          out_of_order;
    logic                          set_count_err;
    logic                          drain_load;
    logic                          drain_adv;
    logic                          drain_last;

    // Order test against the previously captured element; equal is legal.
    assign out_of_order = (ASCENDING != 0) ? (SM_data < prev_data)
                                           : (SM_data > prev_data);
    assign rd_ptr_inc   = rd_ptr + ADDR_ONE;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_nxt     = state;
        cap_we        = 1'b0;
        set_count_err = 1'b0;
        drain_load    = 1'b0;
        drain_adv     = 1'b0;
        drain_last    = 1'b0;
        case (state)
            // IDLE behaves like CAPTURE: the first strobe is already a write.
            ST_IDLE, ST_CAPTURE: begin
                cap_we = SM_valid;
                if (sorter_done) begin
                    // Done together with the last-address write is a clean end.
                    state_nxt     = ST_DRAIN;
                    set_count_err = !(SM_valid && (SM_addr == LAST_ADDR));
                end else if (SM_valid) begin
                    state_nxt = (SM_addr == LAST_ADDR) ? ST_WAIT_DONE : ST_CAPTURE;
                end
            end
            // The sorter keeps valid high on its last address here; ignore it.
            ST_WAIT_DONE: begin
                if (sorter_done) begin
                    state_nxt = ST_DRAIN;
                end
            end
            // First DRAIN cycle primes out_data; afterwards advance per handshake.
            ST_DRAIN: begin
                if (!out_valid) begin
                    drain_load = 1'b1;
                end else if (out_ready) begin
                    if (rd_ptr == LAST_ADDR) begin
                        drain_last = 1'b1;
                        state_nxt  = ST_FINISH;
                    end else begin
                        drain_adv = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_nxt = ST_FINISH;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture buffer; contents survive reset so stale entries can be drained.
    always_ff @(posedge clk) begin
        if (cap_we) begin
            mem[SM_addr] <= SM_data;
        end
    end

    // Capture bookkeeping, sticky error flags and the registered drain port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_data <= '0;
            exp_addr  <= '0;
            wr_cnt    <= '0;
            addr_err  <= 1'b0;
            order_err <= 1'b0;
            count_err <= 1'b0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            complete  <= 1'b0;
        end else begin
            if (cap_we) begin
                prev_data <= SM_data;
                exp_addr  <= SM_addr + ADDR_ONE;
                // Saturate so a runaway writer never looks like a first write.
                if (wr_cnt != CNT_MAX) begin
                    wr_cnt <= wr_cnt + CNT_ONE;
                end
                if (SM_addr != exp_addr) begin
                    addr_err <= 1'b1;
                end
                if ((wr_cnt != '0) && out_of_order) begin
                    order_err <= 1'b1;
                end
            end
            if (set_count_err) begin
                count_err <= 1'b1;
            end
            if (drain_load) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
            end
            if (drain_adv) begin
                rd_ptr   <= rd_ptr_inc;
                out_data <= mem[rd_ptr_inc];
            end
            if (drain_last) begin
                out_valid <= 1'b0;
                complete  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_collector
//  Description : Self-checking bench for sm_collector (8 x 8-bit, ascending).
//                Directed batches plus randomized batches against a
//                queue-based reference model of the capture/drain rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sm_collector;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int LG = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          SM_valid = 1'b0;
    logic [LG-1:0] SM_addr = '0;
    logic [DW-1:0] SM_data = '0;
    logic          sorter_done = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          complete;
    logic          addr_err;
    logic          count_err;
    logic          order_err;

    sm_collector #(
        .DATA_WIDTH       (DW),
        .ELEMENT_NUM      (N),
        .LOG2_ELEMENT_NUM (LG),
        .ASCENDING        (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .SM_valid    (SM_valid),
        .SM_addr     (SM_addr),
        .SM_data     (SM_data),
        .sorter_done (sorter_done),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .complete    (complete),
        .addr_err    (addr_err),
        .count_err   (count_err),
        .order_err   (order_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int mem_m [N];
    int wa[$];
    int wd[$];
    bit capturing;
    bit done_early;

    function automatic bit m_addr_err();
        for (int i = 0; i < wa.size(); i++) begin
            int e;
            e = (i == 0) ? 0 : (wa[i-1] + 1) % N;
            if (wa[i] != e) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_order_err();
        for (int i = 1; i < wd.size(); i++) begin
            if (wd[i] < wd[i-1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit rdy(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    32'(out_valid), 32'd0);
        check({tag, "_data"},     32'(out_data),  32'd0);
        check({tag, "_complete"}, 32'(complete),  32'd0);
        check({tag, "_addr_err"}, 32'(addr_err),  32'd0);
        check({tag, "_cnt_err"},  32'(count_err), 32'd0);
        check({tag, "_ord_err"},  32'(order_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; SM_valid = 1'b0; sorter_done = 1'b0; out_ready = 1'b0;
        SM_addr = '0; SM_data = '0;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        wa.delete(); wd.delete();
        capturing  = 1'b1;
        done_early = 1'b0;
    endtask

    task automatic sm_write(input int a, input int d);
        @(negedge clk);
        SM_valid = 1'b1; SM_addr = a[LG-1:0]; SM_data = d[DW-1:0];
        @(posedge clk);
        if (capturing) begin
            wa.push_back(a); wd.push_back(d); mem_m[a] = d;
            if (a == N - 1) capturing = 1'b0;
        end
        #1;
        check("wr_addr_err",  32'(addr_err),  32'(m_addr_err()));
        check("wr_order_err", 32'(order_err), 32'(m_order_err()));
    endtask

    // Raise done, drain with the given ready pattern; abort_after>0 resets
    // the DUT right after that many handshakes.
    task automatic drain(input int mode, input int abort_after);
        int idx = 0;
        int cyc = 0;
        int first_valid = -1;
        bit stalled = 1'b0;
        bit aborted = 1'b0;
        logic [DW-1:0] held = '0;
        @(negedge clk);
        SM_valid = 1'b0; sorter_done = 1'b1; out_ready = rdy(mode, 0);
        while (idx < N && cyc < 200) begin
            @(posedge clk);
            if (cyc == 0) begin
                done_early = capturing;
                capturing  = 1'b0;
            end
            if (abort_after > 0 && idx == abort_after) begin
                #2 rst = 1'b1;
                #1 check_all_zero("async_rst");
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("drn_cnt_err",  32'(count_err), 32'(done_early));
                check("drn_addr_err", 32'(addr_err),  32'(m_addr_err()));
                check("drn_ord_err",  32'(order_err), 32'(m_order_err()));
            end
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data",  32'(out_data),  32'(held));
            end
            out_ready = rdy(mode, cyc);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                check("drain_data", 32'(out_data), 32'(mem_m[idx]));
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held    = out_data;
            end
        end
        if (!aborted) begin
            check("drain_count", 32'(idx), 32'(N));
            @(posedge clk);
            @(negedge clk);
            cyc++;
            check("fin_complete",  32'(complete),  32'd1);
            check("fin_valid",     32'(out_valid), 32'd0);
            check("fin_cnt_err",   32'(count_err), 32'(done_early));
            check("fin_addr_err",  32'(addr_err),  32'(m_addr_err()));
            check("fin_ord_err",   32'(order_err), 32'(m_order_err()));
            if (mode == 0) begin
                check("first_valid_lat", 32'(first_valid), 32'd2);
                check("drain_cycles",    32'(cyc),         32'(N + 2));
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic batch(input int d[N], input int a[N], input int nw,
                         input int hold, input int mode, input int abort_after);
        do_reset();
        for (int i = 0; i < nw; i++) sm_write(a[i], d[i]);
        for (int h = 0; h < hold; h++) sm_write(a[nw-1], d[nw-1]);
        drain(mode, abort_after);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[N];
        seq = '{0, 1, 2, 3, 4, 5, 6, 7};
        #1 check_all_zero("init");

        // Ascending clean capture, last address held two extra cycles.
        batch('{1, 2, 2, 5, 7, 9, 9, 200}, seq, N, 2, 0, 0);
        // Order fault at the addr-2 write.
        batch('{3, 4, 2, 5, 6, 7, 8, 9}, seq, N, 0, 0, 0);
        // Address skip (2 never written; drains stale value).
        batch('{10, 11, 12, 13, 14, 15, 16, 0}, '{0, 1, 3, 4, 5, 6, 7, 0}, 7, 1, 0, 0);
        // Early done after 5 writes.
        batch('{20, 21, 22, 23, 24, 0, 0, 0}, seq, 5, 0, 0, 0);
        // Backpressure 1,0,0,1.
        batch('{5, 6, 7, 8, 9, 10, 11, 12}, seq, N, 1, 1, 0);
        // Reset mid-drain, then a fresh batch.
        batch('{30, 31, 32, 33, 34, 35, 36, 37}, seq, N, 0, 0, 3);
        batch('{40, 41, 42, 43, 44, 45, 46, 47}, seq, N, 0, 0, 0);

        // Randomized batches.
        for (int r = 0; r < 12; r++) begin
            int d[N];
            int a[N];
            int v;
            int nw;
            int hold;
            int kind;
            v = int'($urandom_range(0, 40));
            for (int i = 0; i < N; i++) begin
                v += int'($urandom_range(0, 30));
                d[i] = (v > 255) ? 255 : v;
                a[i] = i;
            end
            nw   = N;
            hold = int'($urandom_range(0, 2));
            kind = r % 4;
            if (kind == 1) begin
                int j;
                int t;
                j = int'($urandom_range(0, N - 2));
                t = d[j]; d[j] = d[j+1]; d[j+1] = t;
            end else if (kind == 2) begin
                int s;
                s  = int'($urandom_range(1, N - 2));
                nw = N - 1;
                for (int i = 0; i < N - 1; i++) begin
                    a[i] = (i < s) ? i : i + 1;
                    d[i] = d[a[i]];
                end
            end else if (kind == 3) begin
                nw   = int'($urandom_range(1, N - 2));
                hold = 0;
            end
            batch(d, a, nw, hold, int'($urandom_range(0, 2)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
